// File: rtl/dmem_if.sv
// Load/store port between the MEM stage (master) and the data memory (slave).
interface dmem_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;

  modport master (
    output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_mbe,
    input  dmem_rdata, dmem_resp, dmem_err
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_mbe,
    output dmem_rdata, dmem_resp, dmem_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed SRAM answering each load/store
// request with a single dmem_resp pulse a fixed LATENCY cycles after it rises.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] req_idx;
  logic [31:0]      req_wdata;
  logic [3:0]       req_mbe;
  logic             req_read;
  logic             req_err;

  logic [31:0] rdata_q;
  logic        resp_q;
  logic        err_q;

  logic             accept;
  logic             in_err;
  logic             fire;
  logic [IDX_W-1:0] f_idx;
  logic [31:0]      f_wdata;
  logic [3:0]       f_mbe;
  logic             f_read;
  logic             f_err;
  logic             unused_addr_lsb;

  // Byte offset bits play no part in word access.
  assign unused_addr_lsb = ^bus.dmem_addr[1:0];

  assign accept = (state == ST_IDLE) && (bus.dmem_read || bus.dmem_write);
  assign in_err = (bus.dmem_read && bus.dmem_write) ||
                  (bus.dmem_addr[31:IDX_W+2] != '0);

  // With LATENCY==1 the access happens on the acceptance edge itself, so the
  // live inputs are used; otherwise the fields latched in IDLE are used.
  assign f_idx   = (LATENCY == 1) ? bus.dmem_addr[IDX_W+1:2] : req_idx;
  assign f_wdata = (LATENCY == 1) ? bus.dmem_wdata           : req_wdata;
  assign f_mbe   = (LATENCY == 1) ? bus.dmem_mbe             : req_mbe;
  assign f_read  = (LATENCY == 1) ? bus.dmem_read            : req_read;
  assign f_err   = (LATENCY == 1) ? in_err                   : req_err;

  // fire marks the edge that moves the FSM into RESP; the access is done there.
  // Gating with rst keeps a pending write from landing while reset is held.
  assign fire = !rst && ((LATENCY == 1) ? accept
                                        : (state == ST_BUSY && cnt == '0));

  assign bus.dmem_rdata = rdata_q;
  assign bus.dmem_resp  = resp_q;
  assign bus.dmem_err   = err_q;

  // Capture the request fields on acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_idx   <= bus.dmem_addr[IDX_W+1:2];
      req_wdata <= bus.dmem_wdata;
      req_mbe   <= bus.dmem_mbe;
      req_read  <= bus.dmem_read;
      req_err   <= in_err;
    end
  end

  // Byte-lane write into the array; erroring requests never modify storage.
  always_ff @(posedge clk) begin
    if (fire && !f_read && !f_err) begin
      for (int i = 0; i < 4; i++) begin
        if (f_mbe[i]) mem[f_idx][8*i +: 8] <= f_wdata[8*i +: 8];
      end
    end
  end

  // Request FSM, latency counter and the registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_BUSY;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_BUSY: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (fire) begin
        resp_q <= 1'b1;
        err_q  <= f_err;
        if (f_read) rdata_q <= f_err ? 32'h0 : mem[f_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, randomized traffic
// against a word-array model, and hand sequences for back-to-back, reset and
// single-cycle-latency behaviour.
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dmem_if bus0 ();
  dmem_if bus1 ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mbe);
    if (which == 0) begin
      bus0.dmem_read = rd; bus0.dmem_write = wr; bus0.dmem_addr = addr;
      bus0.dmem_wdata = wdata; bus0.dmem_mbe = mbe;
    end else begin
      bus1.dmem_read = rd; bus1.dmem_write = wr; bus1.dmem_addr = addr;
      bus1.dmem_wdata = wdata; bus1.dmem_mbe = mbe;
    end
  endtask

  function automatic logic get_resp(input int which);
    return (which == 0) ? bus0.dmem_resp : bus1.dmem_resp;
  endfunction

  // Count rising edges until resp is seen at a falling edge; -1 on timeout.
  task automatic wait_resp(input int which, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (get_resp(which)) seen = 1'b1;
    end
    if (!seen) n = -1;
  endtask

  task automatic txn(input int which, input string name, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mbe,
                     input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                     input int exp_lat);
    int n;
    logic [31:0] rdv;
    logic errv;
    @(negedge clk);
    drive(which, rd, wr, addr, wdata, mbe);
    wait_resp(which, n);
    rdv  = (which == 0) ? bus0.dmem_rdata : bus1.dmem_rdata;
    errv = (which == 0) ? bus0.dmem_err : bus1.dmem_err;
    drive(which, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk({name, "_lat"}, 32'(n), 32'(exp_lat));
    chk({name, "_err"}, {31'h0, errv}, {31'h0, exp_err});
    if (chk_rd) chk({name, "_rdata"}, rdv, exp_rd);
    @(negedge clk);
    chk({name, "_resp_one_cycle"}, {31'h0, get_resp(which)}, 32'h0);
  endtask

  vec_t        vecs[16];
  logic [31:0] model[16];
  logic [31:0] last_rd;

  initial begin
    int n;
    int pulses;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h10,       32'h11223344, 4'h5, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 1'b1, 32'hDE22BE44};
    vecs[4]  = '{1'b0, 1'b1, 32'h00,       32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 32'hDE22BE44};
    vecs[5]  = '{1'b1, 1'b0, 32'h1000,     32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h00,       32'h0,        4'h0, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 1'b1, 32'h20,       32'h12345678, 4'hF, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 1'b1, 32'h20,       32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h20,       32'h0,        4'h0, 1'b0, 1'b1, 32'h12345678};
    vecs[10] = '{1'b0, 1'b1, 32'h20,       32'hAAAAAAAA, 4'h0, 1'b0, 1'b1, 32'h12345678};
    vecs[11] = '{1'b1, 1'b0, 32'h22,       32'h0,        4'h0, 1'b0, 1'b1, 32'h12345678};
    vecs[12] = '{1'b0, 1'b1, 32'h1010,     32'h00000000, 4'hF, 1'b1, 1'b1, 32'h12345678};
    vecs[13] = '{1'b1, 1'b0, 32'h13,       32'h0,        4'h0, 1'b0, 1'b1, 32'hDE22BE44};
    vecs[14] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 32'h30,       32'h0BADC0DE, 4'hF, 1'b0, 1'b1, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_resp",  {31'h0, bus0.dmem_resp}, 32'h0);
    chk("reset_err",   {31'h0, bus0.dmem_err},  32'h0);
    chk("reset_rdata", bus0.dmem_rdata,         32'h0);
    chk("reset_rdata_l1", bus1.dmem_rdata,      32'h0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      txn(0, $sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].mbe, vecs[i].exp_err, vecs[i].chk_rd, vecs[i].exp_rd, 2);
    end

    // Randomized traffic over a 16-word pool at 0x100 against the model
    last_rd = 32'h0;
    for (int k = 0; k < 16; k++) begin
      model[k] = $urandom;
      txn(0, $sformatf("init%0d", k), 1'b0, 1'b1, 32'h100 + 32'(k*4), model[k], 4'hF,
          1'b0, 1'b1, last_rd, 2);
    end
    for (int i = 0; i < 150; i++) begin
      logic        oor, rd;
      int          k;
      logic [31:0] addr, wdata, exp;
      logic [3:0]  mbe;
      oor   = ($urandom_range(0, 9) == 0);
      rd    = 1'($urandom_range(0, 1));
      k     = $urandom_range(0, 15);
      addr  = 32'h100 + 32'(k*4) + 32'($urandom_range(0, 3));
      if (oor) addr = addr | (32'h1 << $urandom_range(12, 31));
      wdata = $urandom;
      mbe   = 4'($urandom_range(0, 15));
      if (rd) begin
        exp = oor ? 32'h0 : model[k];
        last_rd = exp;
      end else begin
        exp = last_rd;
        if (!oor) begin
          for (int b = 0; b < 4; b++)
            if (mbe[b]) model[k][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      txn(0, $sformatf("rand%0d", i), rd, ~rd, addr, wdata, mbe, oor, 1'b1, exp, 2);
    end

    // Back-to-back held reads; address change during BUSY is ignored
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h55555555, 4'hF);
    n = 1;
    begin
      int m;
      wait_resp(0, m);
      n = (m < 0) ? -1 : n + m;
    end
    chk("b2b_first_lat", 32'(n), 32'd2);
    chk("b2b_first_rdata", bus0.dmem_rdata, 32'hDE22BE44);
    wait_resp(0, n);
    chk("b2b_spacing", 32'(n), 32'd3);
    chk("b2b_second_rdata", bus0.dmem_rdata, 32'hCAFEF00D);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);

    // Reset during a BUSY write to 0x30 drops the write
    drive(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_rdata", bus0.dmem_rdata, 32'h0);
    chk("rst_async_resp", {31'h0, bus0.dmem_resp}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus0.dmem_resp) pulses++;
    end
    chk("rst_no_resp", 32'(pulses), 32'd0);
    txn(0, "rst_keep30", 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0BADC0DE, 2);

    // Single-cycle latency instance
    txn(1, "l1_wr", 1'b0, 1'b1, 32'h8, 32'h5A5AA5A5, 4'hF, 1'b0, 1'b1, 32'h0, 1);
    txn(1, "l1_rd", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5A5AA5A5, 1);
    txn(1, "l1_oor", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 1);
    txn(1, "l1_part", 1'b0, 1'b1, 32'h8, 32'h77000000, 4'h8, 1'b0, 1'b1, 32'h0, 1);
    txn(1, "l1_rd2", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b1, 32'h775AA5A5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
